// File: rtl/derivative_filter.sv
// Time-multiplexed multi-channel derivative filter: either an ND-lag difference with
// saturation, or a five-point derivative scaled by 1/8 with floor rounding.
module derivative_filter #(
  parameter int unsigned NBIT = 16,
  parameter int unsigned ND   = 4,
  parameter int unsigned NCH  = 2,
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [CW-1:0]          in_ch,
  input  logic signed [NBIT-1:0] din,
  input  logic                   mode,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [CW-1:0]          out_ch,
  output logic signed [NBIT-1:0] dout,
  output logic                   sat,
  output logic                   primed,
  output logic                   ch_err
);

  localparam int unsigned     CNTW     = $clog2(ND + 1);
  localparam int unsigned     SW       = NBIT + 3;
  localparam logic [CW:0]     NCH_LIM  = (CW + 1)'(NCH);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(ND);
  localparam logic [NBIT-1:0] POS_MAX  = {1'b0, {(NBIT-1){1'b1}}};
  localparam logic [NBIT-1:0] NEG_MIN  = {1'b1, {(NBIT-1){1'b0}}};

  logic signed [NBIT-1:0] hist [NCH][ND];
  logic [CNTW-1:0]        cnt  [NCH];

  logic            ch_ok;
  logic            accept;
  logic            reject;
  logic [CW-1:0]   sel;
  logic [NBIT-1:0] h0;
  logic [NBIT-1:0] h2;
  logic [NBIT-1:0] h3;
  logic [NBIT-1:0] hl;
  logic [NBIT:0]   lag_diff;
  logic [SW-1:0]   five_sum;
  logic [NBIT-1:0] y_next;
  logic            sat_next;
  logic            primed_next;

  // Sample qualification; out-of-range channels are steered to a safe index
  always_comb begin
    ch_ok  = ({1'b0, in_ch} < NCH_LIM);
    accept = in_valid & ~flush & ch_ok;
    reject = in_valid & ~flush & ~ch_ok;
    sel    = ch_ok ? in_ch : '0;
  end

  // Derivative datapath for the addressed channel
  always_comb begin
    h0          = hist[sel][0];
    h2          = hist[sel][2];
    h3          = hist[sel][3];
    hl          = hist[sel][ND-1];
    primed_next = (cnt[sel] == CNT_FULL);
    lag_diff    = {din[NBIT-1], din} - {hl[NBIT-1], hl};
    five_sum    = {{2{din[NBIT-1]}}, din, 1'b0}
                + {{3{h0[NBIT-1]}}, h0}
                - {{3{h2[NBIT-1]}}, h2}
                - {{2{h3[NBIT-1]}}, h3, 1'b0};
    y_next      = lag_diff[NBIT-1:0];
    sat_next    = 1'b0;
    if (mode) begin
      // Dropping the low three bits is a floor divide by 8; the result always fits
      y_next = five_sum[SW-1:3];
    end else if (lag_diff[NBIT] != lag_diff[NBIT-1]) begin
      sat_next = 1'b1;
      y_next   = lag_diff[NBIT] ? NEG_MIN : POS_MAX;
    end
  end

  // Channel histories and fill counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        cnt[c] <= '0;
        for (int unsigned k = 0; k < ND; k++) begin
          hist[c][k] <= '0;
        end
      end
    end else if (flush) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        cnt[c] <= '0;
        for (int unsigned k = 0; k < ND; k++) begin
          hist[c][k] <= '0;
        end
      end
    end else if (accept) begin
      for (int unsigned k = ND - 1; k > 0; k--) begin
        hist[sel][k] <= hist[sel][k-1];
      end
      hist[sel][0] <= din;
      if (cnt[sel] != CNT_FULL) begin
        cnt[sel] <= cnt[sel] + CNTW'(1);
      end
    end
  end

  // Registered results; payload holds while out_valid is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      dout      <= '0;
      sat       <= 1'b0;
      primed    <= 1'b0;
      ch_err    <= 1'b0;
    end else begin
      out_valid <= accept;
      ch_err    <= reject;
      if (accept) begin
        out_ch <= in_ch;
        dout   <= y_next;
        sat    <= sat_next;
        primed <= primed_next;
      end
    end
  end

endmodule

// File: tb/tb_derivative_filter.sv
// Self-checking bench for derivative_filter: directed table, corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_derivative_filter;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [1:0]         in_ch;
  logic signed [15:0] din;
  logic               mode;
  logic               flush;
  logic               out_valid;
  logic [1:0]         out_ch;
  logic signed [15:0] dout;
  logic               sat;
  logic               primed;
  logic               ch_err;

  derivative_filter #(.NBIT(16), .ND(4), .NCH(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .din(din),
    .mode(mode), .flush(flush), .out_valid(out_valid), .out_ch(out_ch),
    .dout(dout), .sat(sat), .primed(primed), .ch_err(ch_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: per-channel sample list (newest first) and fill counts
  int mh [3][4];
  int mc [3];
  bit e_valid, e_sat, e_primed, e_err;
  int e_dout, e_ch;

  typedef struct {
    bit v; int ch; int d; bit m; bit f;
    int x_dout; bit x_sat; bit x_primed;
  } vec_t;
  vec_t tbl[$];

  function automatic void chk(string tag, string field, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s %s: got %0d expected %0d", tag, field, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      mc[c] = 0;
      for (int k = 0; k < 4; k++) mh[c][k] = 0;
    end
    e_valid = 0; e_sat = 0; e_primed = 0; e_err = 0; e_dout = 0; e_ch = 0;
  endfunction

  function automatic int floor_div8(int y);
    int q;
    q = y / 8;
    if ((y % 8 != 0) && (y < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model_step(bit v, int ch, int d, bit m, bit f);
    int y;
    e_valid = 0;
    e_err   = 0;
    if (f) begin
      for (int c = 0; c < 3; c++) begin
        mc[c] = 0;
        for (int k = 0; k < 4; k++) mh[c][k] = 0;
      end
    end else if (v && ch >= 3) begin
      e_err = 1;
    end else if (v) begin
      if (!m) begin
        y = d - mh[ch][3];
        e_sat = 0;
        if (y > 32767) begin y = 32767; e_sat = 1; end
        else if (y < -32768) begin y = -32768; e_sat = 1; end
      end else begin
        y = floor_div8(2 * d + mh[ch][0] - mh[ch][2] - 2 * mh[ch][3]);
        e_sat = 0;
      end
      e_primed = (mc[ch] >= 4);
      for (int k = 3; k > 0; k--) mh[ch][k] = mh[ch][k-1];
      mh[ch][0] = d;
      if (mc[ch] < 4) mc[ch]++;
      e_dout  = y;
      e_ch    = ch;
      e_valid = 1;
    end
  endfunction

  function automatic void check_all(string tag);
    chk(tag, "out_valid", int'(out_valid), int'(e_valid));
    chk(tag, "ch_err",    int'(ch_err),    int'(e_err));
    chk(tag, "dout",      int'(dout),      e_dout);
    chk(tag, "out_ch",    int'(out_ch),    e_ch);
    chk(tag, "sat",       int'(sat),       int'(e_sat));
    chk(tag, "primed",    int'(primed),    int'(e_primed));
  endfunction

  task automatic apply(string tag, bit v, int ch, int d, bit m, bit f);
    in_valid = v;
    in_ch    = 2'(ch);
    din      = 16'(d);
    mode     = m;
    flush    = f;
    model_step(v, ch, d, m, f);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    check_all("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; din = '0; mode = 1'b0; flush = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Lag ramp on ch0, then negative full-scale into ch1 followed by positive full-scale
    tbl.push_back('{1, 0, 0,      0, 0, 0,      0, 0});
    tbl.push_back('{1, 0, 10,     0, 0, 10,     0, 0});
    tbl.push_back('{1, 0, 20,     0, 0, 20,     0, 0});
    tbl.push_back('{1, 0, 30,     0, 0, 30,     0, 0});
    tbl.push_back('{1, 0, 40,     0, 0, 40,     0, 1});
    tbl.push_back('{1, 0, 50,     0, 0, 40,     0, 1});
    tbl.push_back('{1, 1, -32768, 0, 0, -32768, 0, 0});
    tbl.push_back('{1, 1, -32768, 0, 0, -32768, 0, 0});
    tbl.push_back('{1, 1, -32768, 0, 0, -32768, 0, 0});
    tbl.push_back('{1, 1, -32768, 0, 0, -32768, 0, 0});
    tbl.push_back('{1, 1, 32767,  0, 0, 32767,  1, 1});
    for (int i = 0; i < tbl.size(); i++) begin
      apply("tbl", tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].m, tbl[i].f);
      chk("tbl_vec", "out_valid", int'(out_valid), 1);
      chk("tbl_vec", "dout",      int'(dout),      tbl[i].x_dout);
      chk("tbl_vec", "sat",       int'(sat),       int'(tbl[i].x_sat));
      chk("tbl_vec", "primed",    int'(primed),    int'(tbl[i].x_primed));
      chk("tbl_vec", "out_ch",    int'(out_ch),    tbl[i].ch);
    end

    // Five-point mode, ch0 ramp interleaved with constant ch2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply("fivept_ch0", 1, 0, 8 * (i + 1), 1, 0);
      chk("fivept_ch0", "out_ch", int'(out_ch), 0);
      if (i == 4) chk("fivept_ch0", "dout", int'(dout), 10);
      apply("fivept_ch2", 1, 2, 100, 1, 0);
      chk("fivept_ch2", "out_ch", int'(out_ch), 2);
      if (i == 4) chk("fivept_ch2", "dout", int'(dout), 0);
    end

    // Floor rounding of a small negative
    do_reset();
    apply("floor", 1, 0, -1, 1, 0);
    chk("floor", "dout", int'(dout), -1);

    // Bad channel leaves history untouched
    apply("pre_err", 1, 0, 5, 0, 0);
    apply("pre_err", 1, 0, 6, 0, 0);
    apply("bad_ch", 1, 3, 777, 0, 0);
    chk("bad_ch", "ch_err",    int'(ch_err),    1);
    chk("bad_ch", "out_valid", int'(out_valid), 0);
    apply("post_err", 1, 0, 9, 0, 0);
    chk("post_err", "dout", int'(dout), 9);
    chk("post_err", "ch_err", int'(ch_err), 0);

    // Flush drops the same-cycle sample and empties histories
    apply("flush", 1, 0, 50, 0, 1);
    chk("flush", "out_valid", int'(out_valid), 0);
    chk("flush", "ch_err",    int'(ch_err),    0);
    apply("post_flush", 1, 0, 7, 0, 0);
    chk("post_flush", "primed", int'(primed), 0);
    chk("post_flush", "dout",   int'(dout),   7);
    apply("pre_rst", 1, 0, 8, 0, 0);
    apply("pre_rst", 1, 0, 9, 0, 0);

    // Asynchronous reset between edges, with a sample offered during reset
    #2;
    rst = 1'b1; in_valid = 1'b1; in_ch = 2'd0; din = 16'sd1234; mode = 1'b0;
    model_reset();
    #1;
    check_all("rst_mid");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    in_valid = 1'b0;
    rst = 1'b0;
    apply("restart", 1, 0, 0, 0, 0);
    chk("restart", "dout", int'(dout), 0);
    apply("restart", 1, 0, 10, 0, 0);
    chk("restart", "dout", int'(dout), 10);
    for (int i = 2; i < 6; i++) apply("restart", 1, 0, 10 * i, 0, 0);

    // Randomized traffic, biased toward full-scale samples
    for (int n = 0; n < 400; n++) begin
      int r, ch, d, sel;
      bit v, m, f;
      r   = $urandom_range(0, 9);
      ch  = (r == 9) ? 3 : (r % 3);
      sel = $urandom_range(0, 3);
      d   = (sel == 0) ? -32768 : (sel == 1) ? 32767 : (int'($urandom_range(0, 65535)) - 32768);
      v   = ($urandom_range(0, 3) != 0);
      m   = 1'($urandom_range(0, 1));
      f   = ($urandom_range(0, 24) == 0);
      apply("rand", v, ch, d, m, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/derivative_filter.md
DERIVATIVE_FILTER -- requirements
Module: derivative_filter

Interface
REQ-001 SHALL have parameter NBIT, default 16: sample and output width, two's complement.
REQ-002 SHALL have parameter ND, default 4: delay depth in samples per channel; ND >= 4 is required.
REQ-003 SHALL have parameter NCH, default 2: number of time-multiplexed channels; CW = max(1, clog2(NCH)).
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: din/in_ch/mode are valid this cycle.
REQ-007 SHALL have port in_ch, input, CW: channel index of the input sample.
REQ-008 SHALL have port din, input, NBIT signed: input sample.
REQ-009 SHALL have port mode, input, 1: 0 = ND-lag difference, 1 = five-point derivative.
REQ-010 SHALL have port flush, input, 1: synchronous clear of all channel histories.
REQ-011 SHALL have port out_valid, output, 1: dout/out_ch/sat/primed are valid.
REQ-012 SHALL have port out_ch, output, CW: channel of the current result.
REQ-013 SHALL have port dout, output, NBIT signed: derivative result.
REQ-014 SHALL have port sat, output, 1: the result was clipped.
REQ-015 SHALL have port primed, output, 1: the channel history was full when the sample arrived.
REQ-016 SHALL have port ch_err, output, 1: one-cycle pulse when a sample with in_ch >= NCH is rejected.

Function
REQ-017 SHALL keep a per-channel history h[c][0..ND-1], where h[c][0] is the most recent prior sample, and a per-channel count that saturates at ND.
REQ-018 SHALL accept a sample when in_valid=1, flush=0 and in_ch < NCH.
REQ-019 On an accepted sample, SHALL shift din into h[in_ch] and increment count[in_ch]; other channels SHALL remain unchanged.
REQ-020 Mode 0 SHALL compute y = din - h[ND-1] at NBIT+1 bits, then saturate to [-2^(NBIT-1), 2^(NBIT-1)-1]; sat=1 exactly when clipping occurs.
REQ-021 Mode 1 SHALL compute y = (2*din + h[0] - h[2] - 2*h[3]) at NBIT+3 bits, then arithmetic shift right by 3 (floor); sat SHALL be 0.
REQ-022 mode SHALL be sampled per accepted sample; changing it SHALL NOT alter histories.
REQ-023 Outputs SHALL be registered with latency 1: an accept at edge k produces out_valid=1 and results after edge k, for one cycle only.
REQ-024 primed SHALL be 1 when count[in_ch] >= ND before the accepted sample; results before priming SHALL still be produced using zero history.
REQ-025 Back-to-back accepts on the same or different channels SHALL be supported every cycle with no stall.
REQ-026 in_valid=1 with in_ch >= NCH SHALL leave all state unchanged, give out_valid=0, and pulse ch_err for one cycle after the edge.
REQ-027 flush=1 SHALL zero every history and count at the edge; a same-cycle in_valid SHALL be dropped, with no out_valid and no ch_err.
REQ-028 When out_valid=0, dout/out_ch/sat/primed SHALL hold their last values.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for a clock, clear all histories, counts, out_valid, dout, out_ch, sat, primed and ch_err to 0.
REQ-030 Operation SHALL resume at the first rising edge after rst is deasserted; a sample presented during reset SHALL be discarded.

Verification (NBIT=16, ND=4, NCH=3)
REQ-031 Mode 0, ch0, samples 0,10,20,30,40,50 -> dout 0,10,20,30,40,40; primed 0,0,0,0,1,1; sat 0.
REQ-032 Mode 0, ch1, four samples of -32768, then 32767 -> last dout=32767, sat=1, primed=1.
REQ-033 Mode 1, ch0 samples 8,16,24,32,40 interleaved with ch2 constant 100 -> 5th ch0 dout=10; ch2 dout=0 once primed; out_ch tracks the input channel.
REQ-034 Mode 1, fresh reset, ch0 sample -1 -> dout=-1 (floor rounding).
REQ-035 in_ch=3 with in_valid -> ch_err pulse, no out_valid; a following ch0 sample shows unchanged history. flush with in_valid in the same cycle -> no output, next sample primed=0.
REQ-036 Assert rst between clock edges mid-stream -> all outputs 0 before the next edge; ramp from REQ-031 restarts with dout 0,10.
